// File: rtl/pipe_hazard_if.sv
// Decode-side inputs and pipeline-control outputs of the LEGv8
// hazard sequencer, bundled for the fetch/decode datapath.
interface pipe_hazard_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [9:0]       id_ctrl;
    logic [4:0]       id_rn;
    logic [4:0]       id_rm;
    logic [4:0]       id_rd;
    logic             ex_zero;
    logic             dmem_ready;

    logic [2:0]       ex_ctrl;
    logic [2:0]       mem_ctrl;
    logic [1:0]       wb_ctrl;
    logic [4:0]       ex_rd;
    logic [4:0]       mem_rd;
    logic [4:0]       wb_rd;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             pc_src;
    logic             dmem_req;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_ctrl, id_rn, id_rm, id_rd,
        output ex_zero, dmem_ready,
        input  ex_ctrl, mem_ctrl, wb_ctrl,
        input  ex_rd, mem_rd, wb_rd,
        input  pc_write, ifid_write, ifid_flush, pc_src,
        input  dmem_req, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_ctrl, id_rn, id_rm, id_rd,
        input  ex_zero, dmem_ready,
        output ex_ctrl, mem_ctrl, wb_ctrl,
        output ex_rd, mem_rd, wb_rd,
        output pc_write, ifid_write, ifid_flush, pc_src,
        output dmem_req, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_sequencer.sv
// LEGv8 5-stage control pipeline: stage control registers, load-use
// bubbles, CBZ flush in MEM and data-memory freeze with timeout.
module pipe_hazard_sequencer #(
    parameter int DELAY       = 0,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input logic          clk,
    input logic          rst_n,
    pipe_hazard_if.slave bus
);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || DELAY < 0) begin : g_bad_param
        $error("pipe_hazard_sequencer: parameter out of range");
    end

    localparam logic [4:0]       XZR     = 5'd31;
    localparam logic [7:0]       TMO     = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
    } idex_t;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
        logic memread;
        logic memwrite;
        logic branch;
    } exmem_t;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
    } memwb_t;

    state_t           state_q, state_n;
    logic [7:0]       wait_q, wait_n;
    logic             err_q, err_n;
    idex_t            ex_q, ex_n;
    exmem_t           mem_q, mem_n;
    memwb_t           wb_q, wb_n;
    logic [4:0]       exrd_q, exrd_n;
    logic [4:0]       memrd_q, memrd_n;
    logic [4:0]       wbrd_q, wbrd_n;
    logic             memz_q, memz_n;
    logic [CNT_W-1:0] stall_q, flush_q;

    idex_t  id_c;
    exmem_t ex_fwd;
    memwb_t mem_fwd;
    logic   dmem_req;
    logic   tmo_hit;
    logic   freeze;
    logic   taken;
    logic   lu;
    logic   do_flush;
    logic   do_lu;
    logic   stall_inc;
    logic   unused_ctrl;

    // Reg2Loc is resolved upstream and UnCondBranch never steers PCSrc here.
    assign unused_ctrl = ^{bus.id_ctrl[9], bus.id_ctrl[2]};

    always_comb begin
        id_c = '0;
        if (bus.id_valid) begin
            id_c.alusrc   = bus.id_ctrl[8];
            id_c.memtoreg = bus.id_ctrl[7];
            id_c.regwrite = bus.id_ctrl[6];
            id_c.memread  = bus.id_ctrl[5];
            id_c.memwrite = bus.id_ctrl[4];
            id_c.branch   = bus.id_ctrl[3];
            id_c.aluop    = bus.id_ctrl[1:0];
        end
    end

    always_comb begin
        ex_fwd.memtoreg  = ex_q.memtoreg;
        ex_fwd.regwrite  = ex_q.regwrite;
        ex_fwd.memread   = ex_q.memread;
        ex_fwd.memwrite  = ex_q.memwrite;
        ex_fwd.branch    = ex_q.branch;
        mem_fwd.memtoreg = mem_q.memtoreg;
        mem_fwd.regwrite = mem_q.regwrite;
    end

    assign dmem_req = mem_q.memread | mem_q.memwrite;
    assign tmo_hit  = (state_q == MEM_WAIT) && (wait_q == TMO)
                      && !bus.dmem_ready;
    assign freeze   = dmem_req && !bus.dmem_ready && !tmo_hit;
    assign taken    = mem_q.branch && memz_q;
    assign lu       = ex_q.memread && (exrd_q != XZR) && bus.id_valid
                      && ((exrd_q == bus.id_rn) || (exrd_q == bus.id_rm));

    // A taken branch squashes the ID instruction, so it outranks load-use.
    assign do_flush  = taken && !freeze;
    assign do_lu     = lu && !taken && !freeze;
    assign stall_inc = freeze || do_lu;

    always_comb begin
        state_n        = RUN;
        wait_n         = '0;
        err_n          = err_q | tmo_hit;
        ex_n           = id_c;
        exrd_n         = bus.id_rd;
        mem_n          = ex_fwd;
        memrd_n        = exrd_q;
        memz_n         = bus.ex_zero;
        wb_n           = mem_fwd;
        wbrd_n         = memrd_q;
        bus.pc_write   = 1'b1;
        bus.ifid_write = 1'b1;
        bus.ifid_flush = 1'b0;
        bus.pc_src     = 1'b0;
        unique case (1'b1)
            freeze: begin
                state_n        = MEM_WAIT;
                wait_n         = wait_q + 8'd1;
                err_n          = err_q;
                ex_n           = ex_q;
                exrd_n         = exrd_q;
                mem_n          = mem_q;
                memrd_n        = memrd_q;
                memz_n         = memz_q;
                wb_n           = wb_q;
                wbrd_n         = wbrd_q;
                bus.pc_write   = 1'b0;
                bus.ifid_write = 1'b0;
            end
            do_flush: begin
                ex_n           = '0;
                exrd_n         = XZR;
                mem_n          = '0;
                memrd_n        = XZR;
                memz_n         = 1'b0;
                wb_n.regwrite  = 1'b0;
                bus.ifid_flush = 1'b1;
                bus.pc_src     = 1'b1;
            end
            do_lu: begin
                ex_n           = '0;
                exrd_n         = XZR;
                bus.pc_write   = 1'b0;
                bus.ifid_write = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            exrd_q  <= '0;
            memrd_q <= '0;
            wbrd_q  <= '0;
            memz_q  <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_n;
            wait_q  <= wait_n;
            err_q   <= err_n;
            ex_q    <= ex_n;
            mem_q   <= mem_n;
            wb_q    <= wb_n;
            exrd_q  <= exrd_n;
            memrd_q <= memrd_n;
            wbrd_q  <= wbrd_n;
            memz_q  <= memz_n;
            if (stall_inc && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_ONE;
            end
            if (do_flush && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_ONE;
            end
        end
    end

    assign bus.ex_ctrl   = {ex_q.alusrc, ex_q.aluop};
    assign bus.mem_ctrl  = {mem_q.memread, mem_q.memwrite, mem_q.branch};
    assign bus.wb_ctrl   = {wb_q.memtoreg, wb_q.regwrite};
    assign bus.ex_rd     = exrd_q;
    assign bus.mem_rd    = memrd_q;
    assign bus.wb_rd     = wbrd_q;
    assign bus.dmem_req  = dmem_req;
    assign bus.mem_err   = err_q;
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Scoreboard bench for pipe_hazard_sequencer: directed LEGv8 sequences
// push per-cycle expectations, a negedge monitor pops and compares.
module tb_pipe_hazard_sequencer;

    localparam logic [9:0] LDUR = 10'h3E0;
    localparam logic [9:0] ADD  = 10'h042;
    localparam logic [9:0] CBZ  = 10'h209;
    localparam logic [9:0] STUR = 10'h310;

    localparam int S_EXC   = 0;
    localparam int S_MEMC  = 1;
    localparam int S_WBC   = 2;
    localparam int S_EXRD  = 3;
    localparam int S_MEMRD = 4;
    localparam int S_WBRD  = 5;
    localparam int S_PCW   = 6;
    localparam int S_IFW   = 7;
    localparam int S_FL    = 8;
    localparam int S_PCS   = 9;
    localparam int S_REQ   = 10;
    localparam int S_ERR   = 11;
    localparam int S_STALL = 12;
    localparam int S_FLUSH = 13;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_run;
    int   n_fail;
    exp_t sbq[$];
    exp_t e;
    logic [31:0] act;

    pipe_hazard_if #(.CNT_W(16)) bus ();

    pipe_hazard_sequencer #(
        .DELAY(0),
        .MEM_TIMEOUT(15),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] sample(int s);
        case (s)
            S_EXC:   return 32'(bus.ex_ctrl);
            S_MEMC:  return 32'(bus.mem_ctrl);
            S_WBC:   return 32'(bus.wb_ctrl);
            S_EXRD:  return 32'(bus.ex_rd);
            S_MEMRD: return 32'(bus.mem_rd);
            S_WBRD:  return 32'(bus.wb_rd);
            S_PCW:   return 32'(bus.pc_write);
            S_IFW:   return 32'(bus.ifid_write);
            S_FL:    return 32'(bus.ifid_flush);
            S_PCS:   return 32'(bus.pc_src);
            S_REQ:   return 32'(bus.dmem_req);
            S_ERR:   return 32'(bus.mem_err);
            S_STALL: return 32'(bus.stall_cnt);
            S_FLUSH: return 32'(bus.flush_cnt);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            n_run++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: stale check from cycle %0d at %0d",
                         e.name, e.cyc, cyc);
            end else begin
                act = sample(e.sel);
                if (act !== e.val) begin
                    n_fail++;
                    $display("FAIL %s (cycle %0d): got %0h, want %0h",
                             e.name, cyc, act, e.val);
                end
            end
        end
    end

    task automatic chk(int s, logic [31:0] v, string nm);
        exp_t x;
        x.cyc  = cyc;
        x.sel  = s;
        x.val  = v;
        x.name = nm;
        sbq.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [9:0] c, logic [4:0] rn,
                         logic [4:0] rm, logic [4:0] rd);
        bus.id_valid = v;
        bus.id_ctrl  = c;
        bus.id_rn    = rn;
        bus.id_rm    = rm;
        bus.id_rd    = rd;
    endtask

    task automatic idle();
        drive(1'b0, 10'h000, 5'd31, 5'd31, 5'd31);
    endtask

    task automatic tickn(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        idle();
        bus.ex_zero    = 1'b0;
        bus.dmem_ready = 1'b1;
        tickn(2);
        chk(S_EXC, 0, "rst_ex_ctrl");
        chk(S_MEMC, 0, "rst_mem_ctrl");
        chk(S_WBC, 0, "rst_wb_ctrl");
        chk(S_EXRD, 0, "rst_ex_rd");
        chk(S_WBRD, 0, "rst_wb_rd");
        chk(S_PCW, 1, "rst_pc_write");
        chk(S_IFW, 1, "rst_ifid_write");
        chk(S_FL, 0, "rst_ifid_flush");
        chk(S_PCS, 0, "rst_pc_src");
        chk(S_REQ, 0, "rst_dmem_req");
        chk(S_ERR, 0, "rst_mem_err");
        chk(S_STALL, 0, "rst_stall_cnt");
        chk(S_FLUSH, 0, "rst_flush_cnt");
        rst_n = 1'b1;

        // Load-use: LDUR X2 then ADD X3,X2,X4
        drive(1'b1, LDUR, 5'd1, 5'd31, 5'd2);
        chk(S_PCW, 1, "lu_first_no_stall");
        tick();
        drive(1'b1, ADD, 5'd2, 5'd4, 5'd3);
        chk(S_EXC, 3'b100, "lu_ldur_ex_ctrl");
        chk(S_EXRD, 2, "lu_ldur_ex_rd");
        chk(S_PCW, 0, "lu_pc_write");
        chk(S_IFW, 0, "lu_ifid_write");
        tick();
        chk(S_EXC, 0, "lu_bubble_ex_ctrl");
        chk(S_EXRD, 31, "lu_bubble_ex_rd");
        chk(S_MEMC, 3'b100, "lu_ldur_mem_ctrl");
        chk(S_MEMRD, 2, "lu_ldur_mem_rd");
        chk(S_REQ, 1, "lu_dmem_req");
        chk(S_PCW, 1, "lu_resume_pc_write");
        chk(S_STALL, 1, "lu_stall_cnt");
        tick();
        idle();
        chk(S_WBC, 2'b11, "lu_ldur_wb_3edges");
        chk(S_WBRD, 2, "lu_ldur_wb_rd");
        chk(S_EXC, 3'b010, "lu_add_ex_ctrl");
        chk(S_EXRD, 3, "lu_add_ex_rd");
        tick();
        chk(S_WBC, 0, "lu_bubble_wb_ctrl");
        chk(S_WBRD, 31, "lu_bubble_wb_rd");
        tick();
        chk(S_WBC, 2'b01, "lu_add_wb_late");
        chk(S_WBRD, 3, "lu_add_wb_rd");

        // LDUR into XZR: no hazard
        tick();
        drive(1'b1, LDUR, 5'd1, 5'd31, 5'd31);
        tick();
        drive(1'b1, ADD, 5'd31, 5'd5, 5'd6);
        chk(S_EXRD, 31, "xzr_ex_rd");
        chk(S_PCW, 1, "xzr_pc_write");
        chk(S_IFW, 1, "xzr_ifid_write");
        tick();
        idle();
        chk(S_EXC, 3'b010, "xzr_add_ex_ctrl");
        chk(S_EXRD, 6, "xzr_add_ex_rd");
        chk(S_STALL, 1, "xzr_stall_cnt");
        tickn(3);

        // CBZ taken
        drive(1'b1, CBZ, 5'd31, 5'd9, 5'd9);
        tick();
        drive(1'b1, ADD, 5'd1, 5'd1, 5'd10);
        bus.ex_zero = 1'b1;
        chk(S_EXC, 3'b001, "br_cbz_ex_ctrl");
        tick();
        drive(1'b1, ADD, 5'd1, 5'd1, 5'd11);
        bus.ex_zero = 1'b0;
        chk(S_PCS, 1, "br_pc_src");
        chk(S_FL, 1, "br_ifid_flush");
        chk(S_PCW, 1, "br_pc_write");
        chk(S_MEMC, 3'b001, "br_mem_ctrl");
        tick();
        idle();
        chk(S_EXC, 0, "br_flush_ex_ctrl");
        chk(S_EXRD, 31, "br_flush_ex_rd");
        chk(S_MEMC, 0, "br_flush_mem_ctrl");
        chk(S_MEMRD, 31, "br_flush_mem_rd");
        chk(S_WBRD, 9, "br_cbz_wb_rd");
        chk(S_PCS, 0, "br_pc_src_one_cycle");
        chk(S_FL, 0, "br_flush_one_cycle");
        chk(S_FLUSH, 1, "br_flush_cnt");
        tick();
        chk(S_WBRD, 31, "br_squash1_wb_rd");
        chk(S_WBC, 0, "br_squash1_wb_ctrl");
        tick();
        chk(S_WBRD, 31, "br_squash2_wb_rd");
        chk(S_FLUSH, 1, "br_flush_cnt_hold");

        // CBZ not taken
        tick();
        drive(1'b1, CBZ, 5'd31, 5'd9, 5'd9);
        tick();
        drive(1'b1, ADD, 5'd1, 5'd1, 5'd10);
        tick();
        drive(1'b1, ADD, 5'd1, 5'd1, 5'd11);
        chk(S_PCS, 0, "nt_pc_src");
        chk(S_FL, 0, "nt_ifid_flush");
        tick();
        idle();
        chk(S_EXC, 3'b010, "nt_ex_ctrl");
        chk(S_EXRD, 11, "nt_ex_rd");
        chk(S_MEMRD, 10, "nt_mem_rd");
        chk(S_FLUSH, 1, "nt_flush_cnt");
        tickn(3);

        // Taken branch and load-use in the same cycle
        drive(1'b1, CBZ, 5'd31, 5'd9, 5'd9);
        tick();
        drive(1'b1, LDUR, 5'd1, 5'd31, 5'd12);
        bus.ex_zero = 1'b1;
        tick();
        drive(1'b1, ADD, 5'd12, 5'd4, 5'd13);
        bus.ex_zero = 1'b0;
        chk(S_PCS, 1, "sim_pc_src");
        chk(S_FL, 1, "sim_ifid_flush");
        chk(S_PCW, 1, "sim_pc_write");
        chk(S_IFW, 1, "sim_ifid_write");
        tick();
        idle();
        chk(S_STALL, 1, "sim_stall_cnt");
        chk(S_FLUSH, 2, "sim_flush_cnt");
        chk(S_EXC, 0, "sim_ex_ctrl");
        chk(S_MEMC, 0, "sim_mem_ctrl");
        tickn(3);

        // STUR waits three cycles for memory
        drive(1'b1, STUR, 5'd1, 5'd13, 5'd13);
        tick();
        drive(1'b1, ADD, 5'd1, 5'd1, 5'd14);
        tick();
        drive(1'b1, ADD, 5'd1, 5'd1, 5'd15);
        bus.dmem_ready = 1'b0;
        chk(S_REQ, 1, "mw_dmem_req");
        chk(S_MEMC, 3'b010, "mw_mem_ctrl");
        chk(S_PCW, 0, "mw_pc_write");
        chk(S_IFW, 0, "mw_ifid_write");
        tick();
        chk(S_EXC, 3'b010, "mw_hold_ex_ctrl");
        chk(S_EXRD, 14, "mw_hold_ex_rd");
        chk(S_MEMRD, 13, "mw_hold_mem_rd");
        chk(S_PCW, 0, "mw_pc_write_2");
        chk(S_STALL, 2, "mw_stall_cnt_2");
        tick();
        chk(S_PCW, 0, "mw_pc_write_3");
        chk(S_MEMRD, 13, "mw_hold_mem_rd_3");
        chk(S_STALL, 3, "mw_stall_cnt_3");
        tick();
        bus.dmem_ready = 1'b1;
        chk(S_PCW, 1, "mw_release_pc_write");
        chk(S_STALL, 4, "mw_stall_cnt_4");
        chk(S_ERR, 0, "mw_mem_err");
        tick();
        idle();
        chk(S_WBRD, 13, "mw_adv_wb_rd");
        chk(S_MEMRD, 14, "mw_adv_mem_rd");
        chk(S_EXRD, 15, "mw_adv_ex_rd");
        chk(S_STALL, 4, "mw_stall_cnt_final");
        tickn(3);

        // Freeze with a pending load-use, then one bubble
        drive(1'b1, STUR, 5'd1, 5'd16, 5'd16);
        tick();
        drive(1'b1, LDUR, 5'd1, 5'd31, 5'd17);
        tick();
        drive(1'b1, ADD, 5'd17, 5'd4, 5'd18);
        bus.dmem_ready = 1'b0;
        chk(S_PCW, 0, "fz_pc_write");
        tick();
        chk(S_EXRD, 17, "fz_hold_ex_rd");
        chk(S_PCW, 0, "fz_pc_write_2");
        chk(S_STALL, 5, "fz_stall_cnt_5");
        tick();
        bus.dmem_ready = 1'b1;
        chk(S_PCW, 0, "fz_lu_pc_write");
        chk(S_IFW, 0, "fz_lu_ifid_write");
        chk(S_STALL, 6, "fz_stall_cnt_6");
        tick();
        chk(S_EXC, 0, "fz_bubble_ex_ctrl");
        chk(S_EXRD, 31, "fz_bubble_ex_rd");
        chk(S_MEMRD, 17, "fz_ldur_mem_rd");
        chk(S_PCW, 1, "fz_resume_pc_write");
        chk(S_STALL, 7, "fz_stall_cnt_7");
        tick();
        idle();
        chk(S_EXRD, 18, "fz_add_ex_rd");
        chk(S_STALL, 7, "fz_single_bubble");
        tickn(3);

        // Memory never ready: forced advance after 15 wait cycles
        drive(1'b1, STUR, 5'd1, 5'd20, 5'd20);
        tick();
        idle();
        tick();
        bus.dmem_ready = 1'b0;
        chk(S_REQ, 1, "to_dmem_req");
        chk(S_PCW, 0, "to_pc_write_first");
        tickn(14);
        chk(S_PCW, 0, "to_pc_write_last");
        chk(S_ERR, 0, "to_no_err_yet");
        chk(S_STALL, 21, "to_stall_cnt_21");
        tick();
        chk(S_PCW, 1, "to_forced_advance");
        chk(S_ERR, 0, "to_err_registered");
        chk(S_STALL, 22, "to_stall_cnt_22");
        tick();
        bus.dmem_ready = 1'b1;
        chk(S_ERR, 1, "to_mem_err");
        chk(S_WBRD, 20, "to_stur_wb_rd");
        chk(S_STALL, 22, "to_stall_cnt_final");
        tickn(3);
        chk(S_ERR, 1, "to_mem_err_sticky");

        // Reset with a LDUR in EX
        drive(1'b1, LDUR, 5'd1, 5'd31, 5'd22);
        tick();
        idle();
        rst_n = 1'b0;
        chk(S_EXC, 0, "mr_ex_ctrl");
        chk(S_EXRD, 0, "mr_ex_rd");
        chk(S_MEMC, 0, "mr_mem_ctrl");
        chk(S_WBC, 0, "mr_wb_ctrl");
        chk(S_PCW, 1, "mr_pc_write");
        chk(S_REQ, 0, "mr_dmem_req");
        chk(S_ERR, 0, "mr_mem_err");
        chk(S_STALL, 0, "mr_stall_cnt");
        chk(S_FLUSH, 0, "mr_flush_cnt");
        tick();
        rst_n = 1'b1;
        drive(1'b1, ADD, 5'd1, 5'd1, 5'd21);
        tick();
        idle();
        tick();
        chk(S_WBC, 0, "mr_wb_ctrl_2edges");
        chk(S_WBRD, 0, "mr_wb_rd_2edges");
        tick();
        chk(S_WBC, 2'b01, "mr_add_wb_3edges");
        chk(S_WBRD, 21, "mr_add_wb_rd");
        tickn(2);

        n_run++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d checks left, want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
